fake_signal_gen: RTL and testbench

Parametrised, per-channel-maskable fake pulse injector, placed between the ADC capture and the filter/trigger modules. Generates programmable ramp, triangle, exponential-decay or square pulses as packed {HG,LG} samples, periodically or on software trigger. Channels with their mask bit clear pass ADC data through with identical latency, so switching modes never misaligns samples.

---
 rtl/fake_signal_pkg.sv | 28 ++
 rtl/fake_pulse_shaper.sv | 149 ++++++++++++++
 rtl/fake_signal_gen.sv | 93 +++++++++
 tb/tb_fake_signal_gen.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fake_signal_pkg.sv
// Shared types, mode encodings and saturating arithmetic for the fake pulse injector.
package fake_signal_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RISE,
    ST_FALL,
    ST_DECAY,
    ST_PLATEAU
  } pulse_state_t;

  localparam logic [1:0] MODE_RAMP   = 2'd0;
  localparam logic [1:0] MODE_TRI    = 2'd1;
  localparam logic [1:0] MODE_EXP    = 2'd2;
  localparam logic [1:0] MODE_SQUARE = 2'd3;

  // Unsigned a+b clamped to 2^width-1; operands are zero-extended by the caller.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int          width);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << width) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/fake_pulse_shaper.sv
// Pulse state machine: latches the pulse settings at start and walks the pulse value v.
module fake_pulse_shaper
  import fake_signal_pkg::*;
#(
  parameter int ADC_WIDTH = 12
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [ADC_WIDTH-1:0] amplitude,
  input  logic [ADC_WIDTH-1:0] step,
  input  logic [15:0]          hold,
  input  logic [3:0]           decay_shift,
  input  logic [ADC_WIDTH-1:0] pedestal,
  input  logic [3:0]           lg_shift,
  output logic [ADC_WIDTH-1:0] pulse_v,
  output logic [ADC_WIDTH-1:0] pedestal_s,
  output logic [3:0]           lg_shift_s,
  output logic                 pulse_active,
  output logic [15:0]          pulse_count
);

  pulse_state_t         state, state_n;
  logic [ADC_WIDTH-1:0] v_n;
  logic [1:0]           mode_s, mode_n;
  logic [ADC_WIDTH-1:0] amp_s, amp_n;
  logic [ADC_WIDTH-1:0] step_s, step_n;
  logic [15:0]          hold_s, hold_n;
  logic [3:0]           dsh_s, dsh_n;
  logic [ADC_WIDTH-1:0] ped_n;
  logic [3:0]           lgs_n;
  logic [15:0]          hold_cnt, hold_cnt_n;
  logic [15:0]          count_n;
  logic [15:0]          hold_eff;
  logic [ADC_WIDTH:0]   rise_sum;
  logic [ADC_WIDTH-1:0] fall_v;
  logic [ADC_WIDTH-1:0] decay_d;

  // State, pulse value and shadow settings register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= ST_IDLE;
      pulse_v      <= '0;
      mode_s       <= '0;
      amp_s        <= '0;
      step_s       <= '0;
      hold_s       <= '0;
      dsh_s        <= '0;
      pedestal_s   <= '0;
      lg_shift_s   <= '0;
      hold_cnt     <= '0;
      pulse_count  <= '0;
      pulse_active <= 1'b0;
    end else begin
      state        <= state_n;
      pulse_v      <= v_n;
      mode_s       <= mode_n;
      amp_s        <= amp_n;
      step_s       <= step_n;
      hold_s       <= hold_n;
      dsh_s        <= dsh_n;
      pedestal_s   <= ped_n;
      lg_shift_s   <= lgs_n;
      hold_cnt     <= hold_cnt_n;
      pulse_count  <= count_n;
      pulse_active <= (state_n != ST_IDLE);
    end
  end

  // Next-state and next pulse value; the one-bit-wider rise sum keeps v from wrapping.
  always_comb begin
    state_n    = state;
    v_n        = pulse_v;
    mode_n     = mode_s;
    amp_n      = amp_s;
    step_n     = step_s;
    hold_n     = hold_s;
    dsh_n      = dsh_s;
    ped_n      = pedestal_s;
    lgs_n      = lg_shift_s;
    hold_cnt_n = hold_cnt;
    count_n    = pulse_count;
    hold_eff   = (hold == 16'd0) ? 16'd1 : hold;
    rise_sum   = {1'b0, pulse_v} + {1'b0, step_s};
    fall_v     = (pulse_v > step_s) ? (pulse_v - step_s) : '0;
    decay_d    = pulse_v >> dsh_s;

    case (state)
      ST_IDLE: begin
        if (start) begin
          mode_n  = mode;
          amp_n   = amplitude;
          step_n  = (step == '0) ? ADC_WIDTH'(1) : step;
          hold_n  = hold_eff;
          dsh_n   = (decay_shift == 4'd0) ? 4'd1 : decay_shift;
          ped_n   = pedestal;
          lgs_n   = lg_shift;
          count_n = pulse_count + 16'd1;
          // A zero amplitude always takes the one-cycle RISE exit, whatever the mode.
          if (mode == MODE_SQUARE && amplitude != '0) begin
            state_n    = ST_PLATEAU;
            v_n        = amplitude;
            hold_cnt_n = hold_eff - 16'd1;
          end else begin
            state_n = ST_RISE;
            v_n     = '0;
          end
        end
      end
      ST_RISE: begin
        if (pulse_v == amp_s) begin
          if (amp_s == '0 || mode_s == MODE_RAMP) begin
            v_n     = '0;
            state_n = ST_IDLE;
          end else if (mode_s == MODE_TRI) begin
            state_n = ST_FALL;
          end else begin
            state_n = ST_DECAY;
          end
        end else begin
          v_n = (rise_sum > {1'b0, amp_s}) ? amp_s : rise_sum[ADC_WIDTH-1:0];
        end
      end
      ST_FALL: begin
        if (pulse_v == '0) state_n = ST_IDLE;
        else               v_n     = fall_v;
      end
      ST_DECAY: begin
        if (decay_d == '0) begin
          v_n     = '0;
          state_n = ST_IDLE;
        end else begin
          v_n = pulse_v - decay_d;
        end
      end
      ST_PLATEAU: begin
        if (hold_cnt == 16'd0) begin
          v_n     = '0;
          state_n = ST_IDLE;
        end else begin
          hold_cnt_n = hold_cnt - 16'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/fake_signal_gen.sv
// Per-channel maskable fake pulse injector between ADC capture and the filters.
module fake_signal_gen
  import fake_signal_pkg::*;
#(
  parameter int NUM_CHAN  = 5,
  parameter int ADC_WIDTH = 12,
  parameter int CNT_WIDTH = 32
) (
  input  logic                            CLK,
  input  logic                            RST_N,
  input  logic [NUM_CHAN-1:0]             USE_FAKE,
  input  logic [NUM_CHAN*2*ADC_WIDTH-1:0] ADC_IN,
  input  logic [CNT_WIDTH-1:0]            PERIOD,
  input  logic                            SOFT_TRIG,
  input  logic [1:0]                      MODE,
  input  logic [ADC_WIDTH-1:0]            AMPLITUDE,
  input  logic [ADC_WIDTH-1:0]            STEP,
  input  logic [15:0]                     HOLD,
  input  logic [3:0]                      DECAY_SHIFT,
  input  logic [ADC_WIDTH-1:0]            PEDESTAL,
  input  logic [3:0]                      LG_SHIFT,
  output logic [NUM_CHAN*2*ADC_WIDTH-1:0] ADC_OUT,
  output logic                            PULSE_ACTIVE,
  output logic [15:0]                     PULSE_COUNT
);

  localparam int WORD_W = 2 * ADC_WIDTH;

  logic [CNT_WIDTH-1:0]         period_cnt;
  logic                         tick;
  logic [ADC_WIDTH-1:0]         pulse_v;
  logic [ADC_WIDTH-1:0]         ped_s;
  logic [3:0]                   lg_shift_s;
  logic [ADC_WIDTH-1:0]         hg_p1;
  logic [ADC_WIDTH-1:0]         lg_p1;
  logic [NUM_CHAN*WORD_W-1:0]   adc_p1;

  // The >= compare lets a shortened PERIOD take effect without waiting for a wrap.
  assign tick = (PERIOD != '0) && (period_cnt >= PERIOD - CNT_WIDTH'(1));

  // Free-running period counter, parked at 0 while automatic pulses are disabled.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                      period_cnt <= '0;
    else if (PERIOD == '0 || tick)   period_cnt <= '0;
    else                             period_cnt <= period_cnt + CNT_WIDTH'(1);
  end

  fake_pulse_shaper #(
    .ADC_WIDTH (ADC_WIDTH)
  ) u_shaper (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .start        (tick | SOFT_TRIG),
    .mode         (MODE),
    .amplitude    (AMPLITUDE),
    .step         (STEP),
    .hold         (HOLD),
    .decay_shift  (DECAY_SHIFT),
    .pedestal     (PEDESTAL),
    .lg_shift     (LG_SHIFT),
    .pulse_v      (pulse_v),
    .pedestal_s   (ped_s),
    .lg_shift_s   (lg_shift_s),
    .pulse_active (PULSE_ACTIVE),
    .pulse_count  (PULSE_COUNT)
  );

  // Stage 1: HG/LG with pedestal, saturating; raw ADC data delayed to match.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hg_p1  <= '0;
      lg_p1  <= '0;
      adc_p1 <= '0;
    end else begin
      hg_p1  <= ADC_WIDTH'(sat_add(32'(ped_s), 32'(pulse_v), ADC_WIDTH));
      lg_p1  <= ADC_WIDTH'(sat_add(32'(ped_s), 32'(pulse_v >> lg_shift_s), ADC_WIDTH));
      adc_p1 <= ADC_IN;
    end
  end

  // Stage 2: per-channel select between fake word and delayed ADC data.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ADC_OUT <= '0;
    end else begin
      for (int i = 0; i < NUM_CHAN; i++) begin
        ADC_OUT[i*WORD_W +: WORD_W] <= USE_FAKE[i] ? {hg_p1, lg_p1}
                                                   : adc_p1[i*WORD_W +: WORD_W];
      end
    end
  end

endmodule

// File: tb/tb_fake_signal_gen.sv
// Scoreboard bench for fake_signal_gen: stimulus queues expected values per cycle, a monitor compares.
module tb_fake_signal_gen;

  localparam int NCH = 5;
  localparam int AW  = 12;
  localparam int WW  = 2 * AW;

  logic              CLK;
  logic              RST_N;
  logic [NCH-1:0]    USE_FAKE;
  logic [NCH*WW-1:0] ADC_IN;
  logic [31:0]       PERIOD;
  logic              SOFT_TRIG;
  logic [1:0]        MODE;
  logic [AW-1:0]     AMPLITUDE;
  logic [AW-1:0]     STEP;
  logic [15:0]       HOLD;
  logic [3:0]        DECAY_SHIFT;
  logic [AW-1:0]     PEDESTAL;
  logic [3:0]        LG_SHIFT;
  logic [NCH*WW-1:0] ADC_OUT;
  logic              PULSE_ACTIVE;
  logic [15:0]       PULSE_COUNT;

  fake_signal_gen #(.NUM_CHAN(NCH), .ADC_WIDTH(AW), .CNT_WIDTH(32)) dut (
    .CLK(CLK), .RST_N(RST_N), .USE_FAKE(USE_FAKE), .ADC_IN(ADC_IN),
    .PERIOD(PERIOD), .SOFT_TRIG(SOFT_TRIG), .MODE(MODE), .AMPLITUDE(AMPLITUDE),
    .STEP(STEP), .HOLD(HOLD), .DECAY_SHIFT(DECAY_SHIFT), .PEDESTAL(PEDESTAL),
    .LG_SHIFT(LG_SHIFT), .ADC_OUT(ADC_OUT), .PULSE_ACTIVE(PULSE_ACTIVE),
    .PULSE_COUNT(PULSE_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // kind: 0 = channel word, 1 = PULSE_ACTIVE, 2 = PULSE_COUNT
  typedef struct { int cyc; int kind; int ch; logic [31:0] val; } exp_t;
  typedef int iq_t[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   finishing = 0;
  bit   drained   = 0;

  function automatic void push(int t, int kind, int ch, logic [31:0] v);
    exp_t e;
    e.cyc = t; e.kind = kind; e.ch = ch; e.val = v;
    sb.push_back(e);
  endfunction

  function automatic logic [31:0] actual(int kind, int ch);
    if (kind == 0)      return {8'h0, ADC_OUT[ch*WW +: WW]};
    else if (kind == 1) return {31'h0, PULSE_ACTIVE};
    else                return {16'h0, PULSE_COUNT};
  endfunction

  function automatic string kname(int kind);
    if (kind == 0)      return "adc_out";
    else if (kind == 1) return "pulse_active";
    else                return "pulse_count";
  endfunction

  function automatic logic [31:0] fake_word(int v, int ped, int lgs);
    int hg;
    int lg;
    hg = ped + v;
    lg = ped + (v >> lgs);
    if (hg > 4095) hg = 4095;
    if (lg > 4095) lg = 4095;
    return {8'h0, 12'(hg), 12'(lg)};
  endfunction

  // Reference pulse: the value v holds on each cycle the generator is outside IDLE.
  function automatic iq_t gen_seq(int mode, int amp, int step, int hold, int dsh);
    iq_t s;
    int  v;
    if (step == 0) step = 1;
    if (hold == 0) hold = 1;
    if (dsh == 0)  dsh  = 1;
    if (mode == 3 && amp != 0) begin
      for (int j = 0; j < hold; j++) s.push_back(amp);
      return s;
    end
    v = 0;
    while (1) begin
      s.push_back(v);
      if (v == amp) break;
      v = (v + step > amp) ? amp : v + step;
    end
    if (amp == 0 || mode == 0) return s;
    v = amp;
    while (1) begin
      s.push_back(v);
      if (mode == 1) begin
        if (v == 0) break;
        v = (v > step) ? v - step : 0;
      end else begin
        if ((v >> dsh) == 0) break;
        v = v - (v >> dsh);
      end
    end
    return s;
  endfunction

  // t0 is the cycle on which the start is sampled; outputs follow two cycles later.
  task automatic expect_pulse(input int t0, input int mode, input int amp, input int step,
                              input int hold, input int dsh, input int ped, input int lgs,
                              input logic [NCH-1:0] chm, input int cnt);
    iq_t s;
    s = gen_seq(mode, amp, step, hold, dsh);
    for (int j = 0; j < s.size(); j++)
      for (int c = 0; c < NCH; c++)
        if (chm[c]) push(t0 + 2 + j, 0, c, fake_word(s[j], ped, lgs));
    for (int c = 0; c < NCH; c++)
      if (chm[c]) push(t0 + 2 + s.size(), 0, c, fake_word(0, ped, lgs));
    push(t0 - 1, 1, 0, 0);
    push(t0, 1, 0, 1);
    push(t0 + s.size() - 1, 1, 0, 1);
    push(t0 + s.size(), 1, 0, 0);
    push(t0 - 1, 2, 0, (cnt - 1) & 32'hFFFF);
    push(t0, 2, 0, cnt & 32'hFFFF);
  endtask

  task automatic soft_fire();
    @(negedge CLK); SOFT_TRIG = 1'b1;
    @(negedge CLK); SOFT_TRIG = 1'b0;
  endtask

  task automatic set_pulse(input int mode, input int amp, input int step, input int hold,
                           input int dsh, input int ped, input int lgs);
    MODE = 2'(mode); AMPLITUDE = AW'(amp); STEP = AW'(step); HOLD = 16'(hold);
    DECAY_SHIFT = 4'(dsh); PEDESTAL = AW'(ped); LG_SHIFT = 4'(lgs);
  endtask

  function automatic logic [WW-1:0] pattern(int c, int i);
    return {12'(c * 7 + i * 300), 12'(4095 - c * 5 - i)};
  endfunction

  // Monitor: compares every queued expectation whose cycle has arrived.
  always @(negedge CLK) begin
    int k;
    logic [31:0] act;
    k = 0;
    while (k < sb.size()) begin
      if (sb[k].cyc <= cyc) begin
        act = actual(sb[k].kind, sb[k].ch);
        total++;
        if (act !== sb[k].val) begin
          bad++;
          $display("FAIL %s ch%0d cyc=%0d got=%0h want=%0h",
                   kname(sb[k].kind), sb[k].ch, sb[k].cyc, act, sb[k].val);
        end
        sb.delete(k);
      end else begin
        k++;
      end
    end
    if (finishing && !drained) begin
      drained = 1;
      total++;
      if (sb.size() != 0) begin
        bad++;
        $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
      end
    end
  end

  initial begin
    int t0;
    int n;
    int q;
    RST_N = 1'b0; USE_FAKE = '0; ADC_IN = '0; PERIOD = '0; SOFT_TRIG = 1'b0;
    set_pulse(0, 0, 0, 0, 0, 0, 0);

    // Reset state
    repeat (2) @(negedge CLK);
    for (int c = 0; c < NCH; c++) push(cyc + 1, 0, c, 0);
    push(cyc + 1, 1, 0, 0);
    push(cyc + 1, 2, 0, 0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);

    // Periodic ramp, all channels fake
    set_pulse(0, 10, 1, 0, 0, 200, 0);
    USE_FAKE = 5'b11111;
    PERIOD   = 32'd100;
    n = cyc;
    expect_pulse(n + 100, 0, 10, 1, 0, 0, 200, 0, 5'b11111, 1);
    expect_pulse(n + 200, 0, 10, 1, 0, 0, 200, 0, 5'b11111, 2);
    push(n + 112, 0, 3, {8'h0, 12'd210, 12'd210});
    repeat (250) @(negedge CLK);
    PERIOD = '0;
    repeat (5) @(negedge CLK);

    // Saturation of HG and LG
    set_pulse(0, 4095, 512, 0, 0, 4000, 5);
    t0 = cyc + 2;
    expect_pulse(t0, 0, 4095, 512, 0, 0, 4000, 5, 5'b11111, 3);
    push(t0 + 3, 0, 0, {8'h0, 12'd4095, 12'd4016});
    push(t0 + 10, 0, 1, {8'h0, 12'd4095, 12'd4095});
    soft_fire();
    repeat (20) @(negedge CLK);

    // Channel mask with triangle pulse and counting ADC pattern
    set_pulse(1, 1024, 256, 0, 0, 100, 2);
    USE_FAKE = 5'b00101;
    t0 = cyc + 2;
    expect_pulse(t0, 1, 1024, 256, 0, 0, 100, 2, 5'b00101, 4);
    push(t0 + 6, 0, 2, {8'h0, 12'd1124, 12'd356});
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      SOFT_TRIG = (c == 0);
      for (int i = 0; i < NCH; i++) ADC_IN[i*WW +: WW] = pattern(cyc, i);
      push(cyc + 2, 0, 1, {8'h0, pattern(cyc, 1)});
      push(cyc + 2, 0, 3, {8'h0, pattern(cyc, 3)});
      push(cyc + 2, 0, 4, {8'h0, pattern(cyc, 4)});
    end
    @(negedge CLK);
    push(cyc + 1, 0, 1, {8'h0, ADC_IN[1*WW +: WW]});
    @(negedge CLK);
    USE_FAKE = 5'b11111;
    q = cyc;
    push(q + 1, 0, 1, {8'h0, 12'd100, 12'd100});
    repeat (5) @(negedge CLK);

    // Exponential decay
    set_pulse(2, 1024, 1024, 0, 2, 50, 1);
    t0 = cyc + 2;
    expect_pulse(t0, 2, 1024, 1024, 0, 2, 50, 1, 5'b11111, 5);
    push(t0 + 5, 0, 0, {8'h0, 12'd818, 12'd434});
    push(t0 + 6, 0, 4, {8'h0, 12'd626, 12'd338});
    soft_fire();
    repeat (35) @(negedge CLK);

    // Collisions: SOFT_TRIG mid-pulse and on a tick cycle
    set_pulse(3, 300, 1, 8, 0, 10, 0);
    PERIOD = 32'd20;
    n = cyc;
    expect_pulse(n + 20, 3, 300, 1, 8, 0, 10, 0, 5'b11111, 6);
    expect_pulse(n + 40, 3, 300, 1, 8, 0, 10, 0, 5'b11111, 7);
    push(n + 30, 2, 0, 6);
    push(n + 61, 1, 0, 0);
    push(n + 65, 2, 0, 7);
    repeat (23) @(negedge CLK);
    SOFT_TRIG = 1'b1;
    @(negedge CLK); SOFT_TRIG = 1'b0;
    repeat (15) @(negedge CLK);
    SOFT_TRIG = 1'b1;
    @(negedge CLK); SOFT_TRIG = 1'b0;
    repeat (5) @(negedge CLK);
    PERIOD = '0;
    repeat (25) @(negedge CLK);

    // Reset mid-plateau
    set_pulse(3, 500, 1, 50, 0, 20, 0);
    t0 = cyc + 2;
    push(t0 + 5, 0, 0, fake_word(500, 20, 0));
    push(t0 + 5, 1, 0, 1);
    push(t0 + 5, 2, 0, 8);
    soft_fire();
    repeat (10) @(negedge CLK);
    @(posedge CLK);
    #1;
    for (int c = 0; c < NCH; c++) push(cyc, 0, c, 0);
    push(cyc, 1, 0, 0);
    push(cyc, 2, 0, 0);
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    push(cyc + 5, 1, 0, 0);
    push(cyc + 20, 2, 0, 0);
    push(cyc + 40, 1, 0, 0);
    push(cyc + 40, 2, 0, 0);
    push(cyc + 40, 0, 0, 0);
    repeat (45) @(negedge CLK);

    finishing = 1;
    repeat (2) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
